// File: rtl/pico_event_port.sv
// Event FIFO, status/data read mux, LED registers and interrupt handshake for the pacoblaze3 I/O port bus.
// Optional feature: define EVENT_DROP_COUNT_EN to add a saturating dropped-event counter at port 8'h02.
module pico_event_port #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] DATA_PORT   = 8'h00,
    parameter logic [7:0] STATUS_PORT = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       event_valid,
    input  logic [7:0] event_data,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [7:0] led,
    output logic       led0
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_CNT = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_SVC
    } irq_state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       count;
    logic             ovf;
    logic             unf;

    logic             empty;
    logic             full;
    logic             data_read;
    logic             push;
    logic             pop;
    logic             drop;
    logic             underflow;
    logic             status_write;
    logic [7:0]       rd_data;

    irq_state_t       state;
    irq_state_t       next_state;

    assign empty        = (count == 4'd0);
    assign full         = (count == DEPTH_CNT);
    assign data_read    = read_strobe && (port_id == DATA_PORT);
    assign pop          = data_read && !empty;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign push         = event_valid && (!full || pop);
    assign drop         = event_valid && !push;
    assign underflow    = data_read && empty;
    assign status_write = write_strobe && (port_id == STATUS_PORT);

    // NOTE: the event storage has no reset; count/pointers define validity, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= event_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle beats a write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (status_write && out_port[7]) begin
                ovf <= 1'b0;
            end
            if (underflow) begin
                unf <= 1'b1;
            end else if (status_write && out_port[6]) begin
                unf <= 1'b0;
            end
        end
    end

`ifdef EVENT_DROP_COUNT_EN
    localparam logic [7:0] DROP_PORT = 8'h02;

    logic [7:0] drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= 8'h00;
        end else if (drop) begin
            if (write_strobe && (port_id == DROP_PORT)) begin
                drop_cnt <= 8'h01;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'h01;
            end
        end else if (write_strobe && (port_id == DROP_PORT)) begin
            drop_cnt <= 8'h00;
        end
    end
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        rd_data = 8'h00;
        if (port_id == DATA_PORT) begin
            rd_data = empty ? 8'h00 : mem[rd_ptr];
        end else if (port_id == STATUS_PORT) begin
            rd_data = {ovf, unf, full, empty, count};
        end
`ifdef EVENT_DROP_COUNT_EN
        else if (port_id == DROP_PORT) begin
            rd_data = drop_cnt;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port <= 8'h00;
        end else begin
            in_port <= rd_data;
        end
    end

    // Output ports are one-hot decoded on port_id bits 7 and 6.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led  <= 8'h00;
            led0 <= 1'b0;
        end else begin
            if (write_strobe && port_id[7]) begin
                led <= out_port;
            end
            if (write_strobe && port_id[6]) begin
                led0 <= out_port[0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= next_state;
            interrupt <= (next_state == ASSERT);
        end
    end

    // The request holds until acked even if the FIFO drains meanwhile.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = ASSERT;
                end
            end
            ASSERT: begin
                if (interrupt_ack) begin
                    next_state = WAIT_SVC;
                end
            end
            WAIT_SVC: begin
                if (data_read) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pico_event_port.sv
// Directed self-checking bench for pico_event_port (default depth 4, ports 8'h00/8'h01).
// Exercises the drop counter at port 8'h02 when EVENT_DROP_COUNT_EN is defined.
module tb_pico_event_port;

    localparam logic [7:0] DATA_ID   = 8'h00;
    localparam logic [7:0] STATUS_ID = 8'h01;
    localparam logic [7:0] DROP_ID   = 8'h02;
    localparam logic [7:0] IDLE_ID   = 8'h03;

    logic       clk = 1'b0;
    logic       reset;
    logic       event_valid;
    logic [7:0] event_data;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] led;
    logic       led0;

    int compared   = 0;
    int mismatched = 0;

    pico_event_port dut (
        .clk           (clk),
        .reset         (reset),
        .event_valid   (event_valid),
        .event_data    (event_data),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .led           (led),
        .led0          (led0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_event(input logic [7:0] d);
        event_valid = 1'b1;
        event_data  = d;
        tick();
        event_valid = 1'b0;
    endtask

    task automatic read_port(input logic [7:0] id, output logic [7:0] val);
        port_id     = id;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        port_id     = IDLE_ID;
        val         = in_port;
    endtask

    task automatic write_port(input logic [7:0] id, input logic [7:0] d);
        port_id      = id;
        out_port     = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = IDLE_ID;
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    // Return to IDLE with an empty FIFO and both sticky flags clear.
    task automatic drain_service();
        logic [7:0] v;
        pulse_ack();
        read_port(DATA_ID, v);
        write_port(STATUS_ID, 8'hC0);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        compared++;
        if (in_port !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_in_port: got %h expected 00", in_port);
        end
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h10) begin
            mismatched++;
            $display("FAIL reset_status: got %h expected 10", v);
        end
        compared++;
        if (interrupt !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_interrupt: got %b expected 0", interrupt);
        end
        compared++;
        if ({led, led0} !== 9'h000) begin
            mismatched++;
            $display("FAIL reset_leds: got led=%h led0=%b expected 00/0", led, led0);
        end
    endtask

    task automatic test_interrupt();
        logic [7:0] v;
        push_event(8'hA5);
        compared++;
        if (interrupt !== 1'b0) begin
            mismatched++;
            $display("FAIL irq_early: got %b expected 0", interrupt);
        end
        tick();
        compared++;
        if (interrupt !== 1'b1) begin
            mismatched++;
            $display("FAIL irq_assert: got %b expected 1", interrupt);
        end
        pulse_ack();
        compared++;
        if (interrupt !== 1'b0) begin
            mismatched++;
            $display("FAIL irq_ack_drop: got %b expected 0", interrupt);
        end
        read_port(DATA_ID, v);
        compared++;
        if (v !== 8'hA5) begin
            mismatched++;
            $display("FAIL irq_data: got %h expected a5", v);
        end
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h10) begin
            mismatched++;
            $display("FAIL irq_status_after: got %h expected 10", v);
        end
        repeat (3) tick();
        compared++;
        if (interrupt !== 1'b0) begin
            mismatched++;
            $display("FAIL irq_no_reassert: got %b expected 0", interrupt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        event_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            event_data = 8'(i);
            tick();
        end
        event_valid = 1'b0;
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'hA4) begin
            mismatched++;
            $display("FAIL ovf_status: got %h expected a4", v);
        end
        for (int i = 1; i <= 4; i++) begin
            read_port(DATA_ID, v);
            compared++;
            if (v !== 8'(i)) begin
                mismatched++;
                $display("FAIL ovf_read%0d: got %h expected %h", i, v, 8'(i));
            end
        end
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h90) begin
            mismatched++;
            $display("FAIL ovf_drained_status: got %h expected 90", v);
        end
        write_port(STATUS_ID, 8'h80);
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h10) begin
            mismatched++;
            $display("FAIL ovf_w1c: got %h expected 10", v);
        end
        drain_service();
    endtask

    task automatic test_simul_full();
        logic [7:0] v;
        logic [7:0] exp_q [4];
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h77};
        push_event(8'h11);
        push_event(8'h22);
        push_event(8'h33);
        push_event(8'h44);
        event_valid = 1'b1;
        event_data  = 8'h77;
        read_port(DATA_ID, v);
        event_valid = 1'b0;
        compared++;
        if (v !== 8'h11) begin
            mismatched++;
            $display("FAIL simul_full_head: got %h expected 11", v);
        end
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h24) begin
            mismatched++;
            $display("FAIL simul_full_status: got %h expected 24", v);
        end
        for (int i = 0; i < 4; i++) begin
            read_port(DATA_ID, v);
            compared++;
            if (v !== exp_q[i]) begin
                mismatched++;
                $display("FAIL simul_full_read%0d: got %h expected %h", i, v, exp_q[i]);
            end
        end
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h10) begin
            mismatched++;
            $display("FAIL simul_full_empty: got %h expected 10", v);
        end
        drain_service();
    endtask

    task automatic test_simul_empty();
        logic [7:0] v;
        event_valid = 1'b1;
        event_data  = 8'h5A;
        read_port(DATA_ID, v);
        event_valid = 1'b0;
        compared++;
        if (v !== 8'h00) begin
            mismatched++;
            $display("FAIL simul_empty_data: got %h expected 00", v);
        end
        read_port(STATUS_ID, v);
        compared++;
        if (v !== 8'h41) begin
            mismatched++;
            $display("FAIL simul_empty_status: got %h expected 41", v);
        end
        read_port(DATA_ID, v);
        compared++;
        if (v !== 8'h5A) begin
            mismatched++;
            $display("FAIL simul_empty_pushed: got %h expected 5a", v);
        end
        drain_service();
    endtask

    task automatic test_reassert();
        logic [7:0] v;
        push_event(8'hAA);
        push_event(8'hBB);
        compared++;
        if (interrupt !== 1'b1) begin
            mismatched++;
            $display("FAIL reassert_first: got %b expected 1", interrupt);
        end
        pulse_ack();
        read_port(DATA_ID, v);
        compared++;
        if ({v, interrupt} !== {8'hAA, 1'b0}) begin
            mismatched++;
            $display("FAIL reassert_read1: got data=%h irq=%b expected aa/0", v, interrupt);
        end
        tick();
        compared++;
        if (interrupt !== 1'b1) begin
            mismatched++;
            $display("FAIL reassert_again: got %b expected 1", interrupt);
        end
        pulse_ack();
        read_port(DATA_ID, v);
        compared++;
        if (v !== 8'hBB) begin
            mismatched++;
            $display("FAIL reassert_read2: got %h expected bb", v);
        end
        repeat (3) tick();
        read_port(STATUS_ID, v);
        compared++;
        if ({v, interrupt} !== {8'h10, 1'b0}) begin
            mismatched++;
            $display("FAIL reassert_quiet: got status=%h irq=%b expected 10/0", v, interrupt);
        end
    endtask

    task automatic test_led();
        write_port(8'h80, 8'h3C);
        compared++;
        if (led !== 8'h3C) begin
            mismatched++;
            $display("FAIL led_write: got %h expected 3c", led);
        end
        write_port(8'h40, 8'h01);
        compared++;
        if ({led, led0} !== {8'h3C, 1'b1}) begin
            mismatched++;
            $display("FAIL led0_write: got led=%h led0=%b expected 3c/1", led, led0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        push_event(8'h12);
        push_event(8'h34);
        port_id = STATUS_ID;
        tick();
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({in_port, interrupt, led, led0} !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got in=%h irq=%b led=%h led0=%b expected all 0",
                     in_port, interrupt, led, led0);
        end
        port_id = IDLE_ID;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        read_port(STATUS_ID, v);
        compared++;
        if ({v, interrupt} !== {8'h10, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_mid_status: got status=%h irq=%b expected 10/0", v, interrupt);
        end
    endtask

    task automatic test_drop_port();
        logic [7:0] v;
`ifdef EVENT_DROP_COUNT_EN
        for (int i = 0; i < 4; i++) begin
            push_event(8'(i));
        end
        event_valid = 1'b1;
        repeat (300) tick();
        event_valid = 1'b0;
        read_port(DROP_ID, v);
        compared++;
        if (v !== 8'hFF) begin
            mismatched++;
            $display("FAIL drop_saturate: got %h expected ff", v);
        end
        write_port(DROP_ID, 8'h00);
        read_port(DROP_ID, v);
        compared++;
        if (v !== 8'h00) begin
            mismatched++;
            $display("FAIL drop_clear: got %h expected 00", v);
        end
`else
        push_event(8'h66);
        read_port(DROP_ID, v);
        compared++;
        if (v !== 8'h00) begin
            mismatched++;
            $display("FAIL drop_port_absent: got %h expected 00", v);
        end
`endif
    endtask

    initial begin
        reset         = 1'b1;
        event_valid   = 1'b0;
        event_data    = 8'h00;
        port_id       = IDLE_ID;
        read_strobe   = 1'b0;
        write_strobe  = 1'b0;
        out_port      = 8'h00;
        interrupt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        test_reset();
        test_interrupt();
        test_overflow();
        test_simul_full();
        test_simul_empty();
        test_reassert();
        test_led();
        test_reset_mid();
        test_drop_port();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
